mul_issue_ctrl: RTL



---
 rtl/constants_pkg.sv | 10 +
 rtl/structure_pkg.sv | 23 ++
 rtl/mul_track_shift.sv | 37 +++
 rtl/mul_issue_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/constants_pkg.sv
// Timing and width constants shared by the multiplier issue-control slice.
package constants_pkg;

    localparam int MUL_LATENCY    = 5;
    localparam int ALU_WB_LATENCY = 1;
    localparam int REG_ADDR_LEN   = 5;
    localparam int INFLIGHT_W     = 3;
    localparam int ISSUED_CNT_W   = 32;

endpackage : constants_pkg

// File: rtl/structure_pkg.sv
// Shared record types for tracking multiplies in flight.
package structure_pkg;

    import constants_pkg::*;

    typedef struct packed {
        logic                    valid;
        logic                    dst_we;
        logic [REG_ADDR_LEN-1:0] dst;
    } mul_track_t;

    // A mul targeting x0 is still tracked, but it never writes the register file.
    function automatic mul_track_t make_track(input logic                    start,
                                              input logic                    we,
                                              input logic [REG_ADDR_LEN-1:0] dst);
        mul_track_t t;
        t.valid  = start;
        t.dst_we = we && (dst != '0);
        t.dst    = dst;
        return t;
    endfunction

endpackage : structure_pkg

// File: rtl/mul_track_shift.sv
// Fixed-length shift register following each accepted mul to its writeback,
// plus the count of entries that have not yet reached the writeback slot.
module mul_track_shift
    import constants_pkg::*;
    import structure_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  mul_track_t                        in_entry,
    output mul_track_t [MUL_LATENCY:1]        pipe,
    output logic       [INFLIGHT_W-1:0]       pending_cnt
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour. Only the valid bits are
    // reset; dst fields are don't-care while their valid bit is low.
    always_ff @(posedge clk) begin
        pipe[1] <= in_entry;
        for (int k = 2; k <= MUL_LATENCY; k++) begin
            pipe[k] <= pipe[k-1];
        end
        if (rst) begin
            for (int k = 1; k <= MUL_LATENCY; k++) begin
                pipe[k].valid <= 1'b0;
            end
        end
    end

    // NOTE: combinational outputs get a default first so no latch is inferred.
    always_comb begin
        pending_cnt = '0;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            pending_cnt = pending_cnt + INFLIGHT_W'(pipe[k].valid);
        end
    end

endmodule : mul_track_shift

// File: rtl/mul_issue_ctrl.sv
// Issue control for a fixed-latency multiplier: RAW/WAW and writeback-port
// hazard detection, multiplier start, writeback tagging and issue counters.
module mul_issue_ctrl
    import constants_pkg::*;
    import structure_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_is_mul,
    input  logic                      issue_dst_we,
    input  logic [REG_ADDR_LEN-1:0]   issue_dst_reg,
    input  logic                      issue_src1_used,
    input  logic [REG_ADDR_LEN-1:0]   issue_src1_reg,
    input  logic                      issue_src2_used,
    input  logic [REG_ADDR_LEN-1:0]   issue_src2_reg,
    input  logic                      flush,
    output logic                      issue_stall,
    output logic                      mul_start,
    output logic                      wb_mul_valid,
    output logic [REG_ADDR_LEN-1:0]   wb_mul_dst,
    output logic                      mul_busy,
    output logic [INFLIGHT_W-1:0]     inflight_cnt,
    output logic [ISSUED_CNT_W-1:0]   mul_issued_cnt
);

    localparam int PORT_SLOT = MUL_LATENCY - ALU_WB_LATENCY;

    mul_track_t [MUL_LATENCY:1]  pipe;
    logic [INFLIGHT_W-1:0]       pending_cnt;
    logic [ISSUED_CNT_W-1:0]     issued_q;
    logic                        raw_hit;
    logic                        waw_hit;
    logic                        port_hit;
    logic                        unused_dst_we;

    mul_track_shift u_track (
        .clk         (clk),
        .rst         (rst),
        .in_entry    (make_track(mul_start, issue_dst_we, issue_dst_reg)),
        .pipe        (pipe),
        .pending_cnt (pending_cnt)
    );

    // The last slot is excluded: the register file is write-first, so a
    // consumer issued in the writeback cycle already sees the result.
    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            if (pipe[k].valid) begin
                if (issue_src1_used && issue_src1_reg != '0 && issue_src1_reg == pipe[k].dst)
                    raw_hit = 1'b1;
                if (issue_src2_used && issue_src2_reg != '0 && issue_src2_reg == pipe[k].dst)
                    raw_hit = 1'b1;
                if (issue_dst_we && issue_dst_reg != '0 && issue_dst_reg == pipe[k].dst)
                    waw_hit = 1'b1;
            end
        end
    end

    // Muls own the writeback port; a non-mul landing there at the same time waits.
    assign port_hit    = !issue_is_mul && issue_dst_we && issue_dst_reg != '0
                         && pipe[PORT_SLOT].valid;
    assign issue_stall = issue_valid && (raw_hit || waw_hit || port_hit);
    assign mul_start   = issue_valid && issue_is_mul && !issue_stall && !flush && !rst;

    assign wb_mul_valid = pipe[MUL_LATENCY].valid && pipe[MUL_LATENCY].dst_we;
    assign wb_mul_dst   = pipe[MUL_LATENCY].dst;

    assign inflight_cnt = pending_cnt;
    assign mul_busy     = (pending_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst)
            issued_q <= '0;
        else if (mul_start)
            issued_q <= issued_q + 1'b1;
    end

    assign mul_issued_cnt = issued_q;

    // Early-slot write enables only matter once they reach writeback.
    always_comb begin
        unused_dst_we = 1'b0;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            unused_dst_we = unused_dst_we ^ pipe[k].dst_we;
        end
    end

endmodule : mul_issue_ctrl
